// File: rtl/sram_arbiter_2x1_if.sv
// Request/response bundle for one master of sram_arbiter_2x1.
// The master drives the request fields; the arbiter returns stall and read data.
interface sram_arbiter_2x1_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic                  en;
  logic [DATA_W/8-1:0]   we;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic                  stall;
  logic                  rvalid;
  logic [DATA_W-1:0]     rdata;

  modport master (
    output en, we, addr, wdata,
    input  stall, rvalid, rdata
  );

  modport slave (
    input  en, we, addr, wdata,
    output stall, rvalid, rdata
  );
endinterface

// File: rtl/sram_arbiter_2x1.sv
// Round-robin arbiter sharing one single-port, 1-cycle-latency RAM between
// the fetch port (m0) and the data port (m1), with per-master read-data hold.
module sram_arbiter_2x1 #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                 clk,
  input  logic                 resetn,
  sram_arbiter_2x1_if.slave    m0,
  sram_arbiter_2x1_if.slave    m1,
  output logic                 ram_en,
  output logic [DATA_W/8-1:0]  ram_we,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic [DATA_W-1:0]    ram_wdata,
  input  logic [DATA_W-1:0]    ram_rdata
);
  localparam int BE_W = DATA_W / 8;

  typedef enum logic {
    GRANT_M0 = 1'b0,
    GRANT_M1 = 1'b1
  } grant_e;

  grant_e last_grant_reg;
  grant_e last_grant_next;
  logic [1:0] grant;

  logic [1:0]        m_en;
  logic [BE_W-1:0]   m_we    [2];
  logic [ADDR_W-1:0] m_addr  [2];
  logic [DATA_W-1:0] m_wdata [2];
  logic [1:0]        m_stall;
  logic [1:0]        m_rvalid;
  logic [DATA_W-1:0] m_rdata [2];

  assign m_en       = {m1.en, m0.en};
  assign m_we[0]    = m0.we;
  assign m_we[1]    = m1.we;
  assign m_addr[0]  = m0.addr;
  assign m_addr[1]  = m1.addr;
  assign m_wdata[0] = m0.wdata;
  assign m_wdata[1] = m1.wdata;

  assign m0.stall  = m_stall[0];
  assign m1.stall  = m_stall[1];
  assign m0.rvalid = m_rvalid[0];
  assign m1.rvalid = m_rvalid[1];
  assign m0.rdata  = m_rdata[0];
  assign m1.rdata  = m_rdata[1];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_grant_reg <= GRANT_M1;
    end else begin
      last_grant_reg <= last_grant_next;
    end
  end

  // Grant and RAM mux; requests are masked entirely while in reset.
  always_comb begin
    grant           = 2'b00;
    last_grant_next = last_grant_reg;
    ram_we          = '0;
    ram_addr        = m_addr[0];
    ram_wdata       = m_wdata[0];

    if (resetn) begin
      case (m_en)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = (last_grant_reg == GRANT_M1) ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end

    if (grant[1]) begin
      last_grant_next = GRANT_M1;
      ram_we          = m_we[1];
      ram_addr        = m_addr[1];
      ram_wdata       = m_wdata[1];
    end else if (grant[0]) begin
      last_grant_next = GRANT_M0;
      ram_we          = m_we[0];
    end
  end

  assign ram_en = |grant;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_master
      logic              rd_reg;
      logic              rd_next;
      logic [DATA_W-1:0] hold_reg;

      assign rd_next = grant[gi] & ~(|m_we[gi]);

      always_ff @(posedge clk) begin
        if (!resetn) begin
          rd_reg   <= 1'b0;
          hold_reg <= '0;
        end else begin
          rd_reg <= rd_next;
          if (rd_reg) begin
            hold_reg <= ram_rdata;
          end
        end
      end

      // rvalid follows the flag even on the first reset cycle after a read.
      assign m_stall[gi]  = resetn & m_en[gi] & ~grant[gi];
      assign m_rvalid[gi] = rd_reg;
      assign m_rdata[gi]  = rd_reg ? ram_rdata : hold_reg;
    end
  endgenerate
endmodule

// File: tb/tb_sram_arbiter_2x1.sv
// Directed bench for sram_arbiter_2x1: a behavioural RAM, a cycle-level
// reference model compared every cycle, and hand-computed spot checks.
module tb_sram_arbiter_2x1;
  localparam int AW = 64;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          resetn;
  logic          ram_en;
  logic [7:0]    ram_we;
  logic [63:0]   ram_addr;
  logic [63:0]   ram_wdata;
  logic [63:0]   ram_rdata;

  sram_arbiter_2x1_if #(.ADDR_W(AW), .DATA_W(DW)) m0_if ();
  sram_arbiter_2x1_if #(.ADDR_W(AW), .DATA_W(DW)) m1_if ();

  sram_arbiter_2x1 #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .m0        (m0_if),
    .m1        (m1_if),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural RAM: 1-cycle read latency, garbage on non-read cycles.
  logic [63:0] ram_mem [logic [63:0]];
  logic [63:0] ram_word;
  always @(posedge clk) begin
    if (ram_en && ram_we == 8'h00) begin
      ram_rdata <= ram_mem.exists(ram_addr) ? ram_mem[ram_addr] : 64'h0;
    end else begin
      ram_rdata <= {$urandom, $urandom};
    end
    if (ram_en && ram_we != 8'h00) begin
      ram_word = ram_mem.exists(ram_addr) ? ram_mem[ram_addr] : 64'h0;
      for (int b = 0; b < 8; b++)
        if (ram_we[b]) ram_word[b*8 +: 8] = ram_wdata[b*8 +: 8];
      ram_mem[ram_addr] = ram_word;
    end
  end

  // Reference model: state as the spec describes it, not as the RTL encodes it.
  logic [63:0] ref_mem [logic [63:0]];
  int          mdl_last;
  logic        mdl_rd   [2];
  logic [63:0] mdl_pend [2];
  logic [63:0] mdl_hold [2];
  logic        in_en    [2];
  logic [7:0]  in_we    [2];
  logic [63:0] in_addr  [2];
  logic [63:0] in_wdata [2];
  int          win;
  logic [63:0] cur;

  initial begin
    mdl_last = 1;
    for (int m = 0; m < 2; m++) begin
      mdl_rd[m] = 1'b0; mdl_pend[m] = 64'h0; mdl_hold[m] = 64'h0;
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      in_en[0] = m0_if.en;  in_we[0] = m0_if.we;  in_addr[0] = m0_if.addr;  in_wdata[0] = m0_if.wdata;
      in_en[1] = m1_if.en;  in_we[1] = m1_if.we;  in_addr[1] = m1_if.addr;  in_wdata[1] = m1_if.wdata;
      win = -1;
      if (resetn) begin
        if (in_en[0] && in_en[1]) win = 1 - mdl_last;
        else if (in_en[0])        win = 0;
        else if (in_en[1])        win = 1;
      end
      check("ram_en", {63'h0, ram_en}, {63'h0, win >= 0});
      check("ram_we", {56'h0, ram_we}, (win >= 0) ? {56'h0, in_we[win]} : 64'h0);
      check("ram_addr", ram_addr, (win == 1) ? in_addr[1] : in_addr[0]);
      check("ram_wdata", ram_wdata, (win == 1) ? in_wdata[1] : in_wdata[0]);
      check("m0_stall", {63'h0, m0_if.stall}, {63'h0, resetn && in_en[0] && win != 0});
      check("m1_stall", {63'h0, m1_if.stall}, {63'h0, resetn && in_en[1] && win != 1});
      check("m0_rvalid", {63'h0, m0_if.rvalid}, {63'h0, mdl_rd[0]});
      check("m1_rvalid", {63'h0, m1_if.rvalid}, {63'h0, mdl_rd[1]});
      check("m0_rdata", m0_if.rdata, mdl_rd[0] ? mdl_pend[0] : mdl_hold[0]);
      check("m1_rdata", m1_if.rdata, mdl_rd[1] ? mdl_pend[1] : mdl_hold[1]);

      // Advance the model to the state after the coming clock edge.
      if (!resetn) begin
        mdl_last = 1;
        for (int m = 0; m < 2; m++) begin
          mdl_rd[m] = 1'b0; mdl_hold[m] = 64'h0;
        end
      end else begin
        for (int m = 0; m < 2; m++) begin
          if (mdl_rd[m]) mdl_hold[m] = mdl_pend[m];
          mdl_rd[m] = 1'b0;
        end
        if (win >= 0) begin
          mdl_last = win;
          cur = ref_mem.exists(in_addr[win]) ? ref_mem[in_addr[win]] : 64'h0;
          if (in_we[win] == 8'h00) begin
            mdl_rd[win]   = 1'b1;
            mdl_pend[win] = cur;
          end else begin
            for (int b = 0; b < 8; b++)
              if (in_we[win][b]) cur[b*8 +: 8] = in_wdata[win][b*8 +: 8];
            ref_mem[in_addr[win]] = cur;
          end
        end
      end
    end
  end

  task automatic drive(input logic e0, input logic [7:0] w0, input logic [63:0] a0, input logic [63:0] d0,
                       input logic e1, input logic [7:0] w1, input logic [63:0] a1, input logic [63:0] d1);
    m0_if.en = e0; m0_if.we = w0; m0_if.addr = a0; m0_if.wdata = d0;
    m1_if.en = e1; m1_if.we = w1; m1_if.addr = a1; m1_if.wdata = d1;
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 64'h0, 64'h0, 1'b0, 8'h00, 64'h0, 64'h0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [63:0] a, input logic [63:0] d);
    ram_mem[a] = d;
    ref_mem[a] = d;
  endtask

  initial begin
    resetn = 1'b0;
    idle();
    preload(64'h1000, 64'hAAAA);
    preload(64'h1008, 64'h1111);
    preload(64'h2008, 64'h2222);
    next_cycle();
    cmp_on = 1'b1;
    @(negedge clk);
    check("rst_ram_en", {63'h0, ram_en}, 64'h0);
    check("rst_m0_rdata", m0_if.rdata, 64'h0);
    next_cycle();
    resetn = 1'b1;

    // m0 read alone
    $display("txn m0 read 0x1000 alone");
    drive(1'b1, 8'h00, 64'h1000, 64'h0, 1'b0, 8'h00, 64'h0, 64'h0);
    @(negedge clk);
    check("t1_ram_en", {63'h0, ram_en}, 64'h1);
    check("t1_m0_stall", {63'h0, m0_if.stall}, 64'h0);
    next_cycle();
    idle();
    @(negedge clk);
    check("t1_m0_rvalid", {63'h0, m0_if.rvalid}, 64'h1);
    check("t1_m0_rdata", m0_if.rdata, 64'hAAAA);
    check("t1_m1_rvalid", {63'h0, m1_if.rvalid}, 64'h0);
    next_cycle();

    // first conflict after a fresh reset goes to m0
    resetn = 1'b0;
    next_cycle();
    resetn = 1'b1;
    $display("txn conflict: m0 read 0x1000, m1 write 0x2000/0x55");
    drive(1'b1, 8'h00, 64'h1000, 64'h0, 1'b1, 8'hFF, 64'h2000, 64'h55);
    @(negedge clk);
    check("t2_m1_stall", {63'h0, m1_if.stall}, 64'h1);
    check("t2_ram_addr", ram_addr, 64'h1000);
    next_cycle();
    drive(1'b0, 8'h00, 64'h0, 64'h0, 1'b1, 8'hFF, 64'h2000, 64'h55);
    @(negedge clk);
    check("t2_ram_we", {56'h0, ram_we}, 64'hFF);
    check("t2_ram_addr_m1", ram_addr, 64'h2000);
    check("t2_m1_stall_lo", {63'h0, m1_if.stall}, 64'h0);
    next_cycle();
    idle();
    next_cycle();

    // continuous reads from both: grants alternate
    $display("txn both read continuously for 6 cycles");
    drive(1'b1, 8'h00, 64'h1000, 64'h0, 1'b1, 8'h00, 64'h2000, 64'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t3_alt_addr", ram_addr, (i % 2 == 0) ? 64'h1000 : 64'h2000);
      next_cycle();
    end
    idle();
    @(negedge clk);
    check("t3_m1_rdata", m1_if.rdata, 64'h55);
    check("t3_m0_hold", m0_if.rdata, 64'hAAAA);
    next_cycle();

    // m0 read then m1 read: m0 keeps its own value
    $display("txn m0 read 0x1008 then m1 read 0x2008");
    drive(1'b1, 8'h00, 64'h1008, 64'h0, 1'b0, 8'h00, 64'h0, 64'h0);
    next_cycle();
    drive(1'b0, 8'h00, 64'h0, 64'h0, 1'b1, 8'h00, 64'h2008, 64'h0);
    @(negedge clk);
    check("t4_m0_rdata_t1", m0_if.rdata, 64'h1111);
    next_cycle();
    idle();
    @(negedge clk);
    check("t4_m0_rdata_t2", m0_if.rdata, 64'h1111);
    check("t4_m1_rdata_t2", m1_if.rdata, 64'h2222);
    check("t4_m1_rvalid_t2", {63'h0, m1_if.rvalid}, 64'h1);
    next_cycle();

    // partial write by m1, then read it back
    $display("txn m1 write 0x2010 we=0x0F");
    drive(1'b0, 8'h00, 64'h0, 64'h0, 1'b1, 8'h0F, 64'h2010, 64'hDEADBEEF_CAFEF00D);
    @(negedge clk);
    check("t5_ram_we", {56'h0, ram_we}, 64'h0F);
    next_cycle();
    idle();
    @(negedge clk);
    check("t5_m1_rvalid", {63'h0, m1_if.rvalid}, 64'h0);
    check("t5_m1_hold", m1_if.rdata, 64'h2222);
    next_cycle();
    $display("txn m1 read 0x2010");
    drive(1'b0, 8'h00, 64'h0, 64'h0, 1'b1, 8'h00, 64'h2010, 64'h0);
    next_cycle();
    idle();
    @(negedge clk);
    check("t5_m1_readback", m1_if.rdata, 64'h00000000_CAFEF00D);
    next_cycle();

    // reset in the middle of alternating traffic
    $display("txn alternating reads interrupted by reset");
    drive(1'b1, 8'h00, 64'h1000, 64'h0, 1'b1, 8'h00, 64'h2000, 64'h0);
    for (int i = 0; i < 3; i++) next_cycle();
    resetn = 1'b0;
    @(negedge clk);
    check("t6_rst_ram_en", {63'h0, ram_en}, 64'h0);
    check("t6_rst_stall", {62'h0, m1_if.stall, m0_if.stall}, 64'h0);
    check("t6_rst_rvalid_flag", {63'h0, m0_if.rvalid}, 64'h1);
    check("t6_rst_rdata_live", m0_if.rdata, 64'hAAAA);
    next_cycle();
    @(negedge clk);
    check("t6_rst_rvalid", {62'h0, m1_if.rvalid, m0_if.rvalid}, 64'h0);
    check("t6_rst_m0_rdata", m0_if.rdata, 64'h0);
    check("t6_rst_m1_rdata", m1_if.rdata, 64'h0);
    next_cycle();
    resetn = 1'b1;
    @(negedge clk);
    check("t6_post_m1_stall", {63'h0, m1_if.stall}, 64'h1);
    check("t6_post_ram_addr", ram_addr, 64'h1000);
    next_cycle();
    drive(1'b0, 8'h00, 64'h0, 64'h0, 1'b1, 8'h00, 64'h2000, 64'h0);
    @(negedge clk);
    check("t6_post_m1_grant", ram_addr, 64'h2000);
    next_cycle();
    idle();
    next_cycle();
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
